// File: rtl/axil_arb_pkg.sv
// Shared types for the AXI-Lite host-port arbiter: FSM states and
// data_size encodings used by the arbiter and its requesters.
package axil_arb_pkg;

  localparam int axil_arb_max_req_lp = 8;

  typedef enum logic [1:0] {
    e_arb   = 2'd0,
    e_issue = 2'd1,
    e_resp  = 2'd2
  } axil_arb_state_e;

  typedef enum logic [1:0] {
    e_size_1b = 2'd0,
    e_size_2b = 2'd1,
    e_size_4b = 2'd2,
    e_size_8b = 2'd3
  } axil_data_size_e;

endpackage

// File: rtl/axil_rr_arb.sv
// Stateless round-robin select: the search starts one past `last` and
// wraps, so the most recent winner has the lowest priority.
module axil_rr_arb
  import axil_arb_pkg::*;
#(
  parameter int num_req_p = 2,
  parameter int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0]     reqs,
  input  logic [lg_num_req_lp-1:0] last,
  output logic [num_req_p-1:0]     grant_oh,
  output logic [lg_num_req_lp-1:0] grant_idx,
  output logic                     v
);

  int                     cand_int_s;
  logic [lg_num_req_lp-1:0] cand_s;

  // Walk the requesters in rotated order and take the first one asserting.
  always_comb begin
    grant_oh   = '0;
    grant_idx  = '0;
    v          = 1'b0;
    cand_int_s = 0;
    cand_s     = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      cand_int_s = int'(last) + i;
      if (cand_int_s >= num_req_p) begin
        cand_int_s = cand_int_s - num_req_p;
      end else begin
        cand_int_s = cand_int_s;
      end
      cand_s = cand_int_s[lg_num_req_lp-1:0];
      if (!v && reqs[cand_s]) begin
        v                = 1'b1;
        grant_idx        = cand_s;
        grant_oh[cand_s] = 1'b1;
      end else begin
        v = v;
      end
    end
  end

endmodule

// File: rtl/axil_master_arbiter.sv
// Shares one axil_master_adaptor host port among num_req_p requesters:
// round-robin grant, one transaction in flight, response routed to the owner.
module axil_master_arbiter
  import axil_arb_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  parameter int lg_num_req_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic [num_req_p-1:0]                         req_v_i,
  output logic [num_req_p-1:0]                         req_yumi_o,
  input  logic [num_req_p-1:0][axil_addr_width_p-1:0]  req_addr_i,
  input  logic [num_req_p-1:0]                         req_wr_en_i,
  input  logic [num_req_p-1:0][1:0]                    req_data_size_i,
  input  logic [num_req_p-1:0][axil_data_width_p-1:0]  req_wdata_i,
  output logic [num_req_p-1:0]                         req_v_o,
  input  logic [num_req_p-1:0]                         req_ready_and_i,
  output logic [axil_data_width_p-1:0]                 req_rdata_o,
  output logic [axil_addr_width_p-1:0]                 addr_o,
  output logic                                         v_o,
  input  logic                                         yumi_i,
  output logic                                         wr_en_o,
  output logic [1:0]                                   data_size_o,
  output logic [axil_data_width_p-1:0]                 wdata_o,
  input  logic                                         v_i,
  output logic                                         ready_and_o,
  input  logic [axil_data_width_p-1:0]                 rdata_i,
  output logic [lg_num_req_lp-1:0]                     owner_o,
  output logic                                         busy_o
);

  typedef struct packed {
    logic [axil_addr_width_p-1:0] addr;
    logic                         wr_en;
    axil_data_size_e              data_size;
    logic [axil_data_width_p-1:0] wdata;
  } axil_host_req_s;

  localparam logic [lg_num_req_lp-1:0] last_init_lp = lg_num_req_lp'(num_req_p - 1);

  axil_arb_state_e          state_r, state_s;
  logic [lg_num_req_lp-1:0] last_r, owner_r;
  axil_host_req_s           payload_r, req_sel_s;
  logic [num_req_p-1:0]     grant_oh_s;
  logic [lg_num_req_lp-1:0] grant_idx_s;
  logic                     arb_v_s, capture_s, owner_ready_s;

  axil_rr_arb #(
    .num_req_p     (num_req_p),
    .lg_num_req_lp (lg_num_req_lp)
  ) rr_arb (
    .reqs      (req_v_i),
    .last      (last_r),
    .grant_oh  (grant_oh_s),
    .grant_idx (grant_idx_s),
    .v         (arb_v_s)
  );

  // Select the winning requester's payload for capture.
  always_comb begin
    req_sel_s.addr      = req_addr_i[grant_idx_s];
    req_sel_s.wr_en     = req_wr_en_i[grant_idx_s];
    req_sel_s.data_size = axil_data_size_e'(req_data_size_i[grant_idx_s]);
    req_sel_s.wdata     = req_wdata_i[grant_idx_s];
  end

  // State, grant history and payload registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_arb;
      last_r    <= last_init_lp;
      owner_r   <= '0;
      payload_r <= '0;
    end else begin
      state_r <= state_s;
      if (capture_s) begin
        payload_r <= req_sel_s;
        owner_r   <= grant_idx_s;
        last_r    <= grant_idx_s;
      end
    end
  end

  // Next state plus handshake outputs; responses only ever reach the owner.
  always_comb begin
    state_s       = state_r;
    capture_s     = 1'b0;
    req_yumi_o    = '0;
    v_o           = 1'b0;
    ready_and_o   = 1'b0;
    req_v_o       = '0;
    owner_ready_s = req_ready_and_i[owner_r];
    case (state_r)
      e_arb: begin
        if (arb_v_s && !reset_i) begin
          req_yumi_o = grant_oh_s;
          capture_s  = 1'b1;
          state_s    = e_issue;
        end else begin
          state_s = e_arb;
        end
      end
      e_issue: begin
        v_o              = 1'b1;
        ready_and_o      = owner_ready_s;
        req_v_o[owner_r] = v_i;
        if (yumi_i && v_i && owner_ready_s) begin
          state_s = e_arb;
        end else if (yumi_i) begin
          state_s = e_resp;
        end else begin
          state_s = e_issue;
        end
      end
      e_resp: begin
        // A second yumi_i here is the adaptor's write-data phase; ignore it.
        ready_and_o      = owner_ready_s;
        req_v_o[owner_r] = v_i;
        if (v_i && owner_ready_s) begin
          state_s = e_arb;
        end else begin
          state_s = e_resp;
        end
      end
      default: begin
        state_s = e_arb;
      end
    endcase
  end

  // Payload toward the adaptor is quiet while arbitrating, held otherwise.
  always_comb begin
    if (state_r == e_arb) begin
      addr_o      = '0;
      wr_en_o     = 1'b0;
      data_size_o = 2'd0;
      wdata_o     = '0;
    end else begin
      addr_o      = payload_r.addr;
      wr_en_o     = payload_r.wr_en;
      data_size_o = payload_r.data_size;
      wdata_o     = payload_r.wdata;
    end
  end

  assign req_rdata_o = rdata_i;
  assign owner_o     = owner_r;
  assign busy_o      = (state_r != e_arb);

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter with two requesters; the bench
// itself plays the adaptor side (yumi_i / v_i / rdata_i).
module tb_axil_master_arbiter;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [1:0]        req_v_i;
  logic [1:0]        req_yumi_o;
  logic [1:0][31:0]  req_addr_i;
  logic [1:0]        req_wr_en_i;
  logic [1:0][1:0]   req_data_size_i;
  logic [1:0][31:0]  req_wdata_i;
  logic [1:0]        req_v_o;
  logic [1:0]        req_ready_and_i;
  logic [31:0]       req_rdata_o;
  logic [31:0]       addr_o;
  logic              v_o;
  logic              yumi_i;
  logic              wr_en_o;
  logic [1:0]        data_size_o;
  logic [31:0]       wdata_o;
  logic              v_i;
  logic              ready_and_o;
  logic [31:0]       rdata_i;
  logic [0:0]        owner_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;

  axil_master_arbiter #(
    .num_req_p         (2),
    .axil_data_width_p (32),
    .axil_addr_width_p (32)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .req_v_i         (req_v_i),
    .req_yumi_o      (req_yumi_o),
    .req_addr_i      (req_addr_i),
    .req_wr_en_i     (req_wr_en_i),
    .req_data_size_i (req_data_size_i),
    .req_wdata_i     (req_wdata_i),
    .req_v_o         (req_v_o),
    .req_ready_and_i (req_ready_and_i),
    .req_rdata_o     (req_rdata_o),
    .addr_o          (addr_o),
    .v_o             (v_o),
    .yumi_i          (yumi_i),
    .wr_en_o         (wr_en_o),
    .data_size_o     (data_size_o),
    .wdata_o         (wdata_o),
    .v_i             (v_i),
    .ready_and_o     (ready_and_o),
    .rdata_i         (rdata_i),
    .owner_o         (owner_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks land 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_i         = 1'b1;
    req_v_i         = 2'b00;
    req_addr_i      = '0;
    req_wr_en_i     = 2'b00;
    req_data_size_i = '0;
    req_wdata_i     = '0;
    req_ready_and_i = 2'b00;
    yumi_i          = 1'b0;
    v_i             = 1'b0;
    rdata_i         = 32'h0;

    // Reset state
    tick(); tick();
    settle();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_yumi", 64'(req_yumi_o), 64'd0);
    chk("rst_req_v_o", 64'(req_v_o), 64'd0);
    chk("rst_ready", 64'(ready_and_o), 64'd0);
    reset_i = 1'b0;
    tick();

    // 1. Single read from req1
    req_v_i = 2'b10; req_addr_i[1] = 32'h0000_1000; req_wr_en_i[1] = 1'b0; req_data_size_i[1] = 2'd2;
    settle();
    chk("t1_yumi", 64'(req_yumi_o), 64'h2);
    chk("t1_arb_v_o", 64'(v_o), 64'd0);
    tick();
    req_v_i = 2'b00; req_ready_and_i = 2'b11;
    settle();
    chk("t1_v_o", 64'(v_o), 64'd1);
    chk("t1_addr", 64'(addr_o), 64'h1000);
    chk("t1_wr_en", 64'(wr_en_o), 64'd0);
    chk("t1_size", 64'(data_size_o), 64'd2);
    chk("t1_owner", 64'(owner_o), 64'd1);
    yumi_i = 1'b1;
    settle();
    chk("t1_issue_req_v_o", 64'(req_v_o), 64'd0);
    tick();
    yumi_i = 1'b0; v_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
    settle();
    chk("t1_resp_v_o", 64'(v_o), 64'd0);
    chk("t1_resp_req_v_o", 64'(req_v_o), 64'h2);
    chk("t1_rdata", 64'(req_rdata_o), 64'hDEAD_BEEF);
    chk("t1_ready", 64'(ready_and_o), 64'd1);
    tick();
    v_i = 1'b0;
    settle();
    chk("t1_done_busy", 64'(busy_o), 64'd0);
    chk("t1_done_req_v_o", 64'(req_v_o), 64'd0);

    // 2. Contention from reset: grants 0,1,0,1 with same-cycle completions
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    req_addr_i[0] = 32'h0000_0A00; req_addr_i[1] = 32'h0000_0B00;
    req_v_i = 2'b11;
    for (int n = 0; n < 4; n++) begin
      yumi_i = 1'b0; v_i = 1'b0;
      settle();
      chk($sformatf("t2_yumi_%0d", n), 64'(req_yumi_o), (n % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      yumi_i = 1'b1; v_i = 1'b1; rdata_i = 32'h0000_1110 + 32'(n);
      settle();
      chk($sformatf("t2_owner_%0d", n), 64'(owner_o), (n % 2 == 0) ? 64'd0 : 64'd1);
      chk($sformatf("t2_issue_yumi_%0d", n), 64'(req_yumi_o), 64'h0);
      chk($sformatf("t2_req_v_o_%0d", n), 64'(req_v_o), (n % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    req_v_i = 2'b00; yumi_i = 1'b0; v_i = 1'b0;

    // 3. Write where the adaptor pulses yumi twice (aw then w)
    req_v_i = 2'b01; req_addr_i[0] = 32'h0000_2000; req_wr_en_i[0] = 1'b1;
    req_data_size_i[0] = 2'd2; req_wdata_i[0] = 32'hCAFE_F00D;
    settle();
    chk("t3_yumi", 64'(req_yumi_o), 64'h1);
    tick();
    req_v_i = 2'b00; req_wdata_i[0] = 32'h0; yumi_i = 1'b1;
    settle();
    chk("t3_wr_en", 64'(wr_en_o), 64'd1);
    chk("t3_wdata_issue", 64'(wdata_o), 64'hCAFE_F00D);
    tick();
    yumi_i = 1'b0;
    settle();
    chk("t3_resp_v_o", 64'(v_o), 64'd0);
    chk("t3_resp_busy", 64'(busy_o), 64'd1);
    tick();
    yumi_i = 1'b1; req_v_i = 2'b10;
    settle();
    chk("t3_second_yumi_wdata", 64'(wdata_o), 64'hCAFE_F00D);
    chk("t3_second_yumi_v_o", 64'(v_o), 64'd0);
    chk("t3_no_yumi_other", 64'(req_yumi_o), 64'h0);
    tick();
    yumi_i = 1'b0; req_v_i = 2'b00;
    settle();
    chk("t3_still_resp", 64'(busy_o), 64'd1);
    chk("t3_addr_hold", 64'(addr_o), 64'h2000);
    v_i = 1'b1;
    settle();
    chk("t3_resp_req_v_o", 64'(req_v_o), 64'h1);
    tick();
    v_i = 1'b0;
    settle();
    chk("t3_done_busy", 64'(busy_o), 64'd0);
    chk("t3_done_v_o", 64'(v_o), 64'd0);

    // 4. Same-cycle read completion
    req_v_i = 2'b10; req_addr_i[1] = 32'h0000_3000; req_wr_en_i[1] = 1'b0;
    settle();
    chk("t4_yumi", 64'(req_yumi_o), 64'h2);
    tick();
    req_v_i = 2'b00; req_ready_and_i = 2'b10;
    yumi_i = 1'b1; v_i = 1'b1; rdata_i = 32'h1234_5678;
    settle();
    chk("t4_req_v_o", 64'(req_v_o), 64'h2);
    chk("t4_ready", 64'(ready_and_o), 64'd1);
    chk("t4_rdata", 64'(req_rdata_o), 64'h1234_5678);
    tick();
    yumi_i = 1'b0; v_i = 1'b0;
    settle();
    chk("t4_done_busy", 64'(busy_o), 64'd0);

    // 5. Backpressure from owner req0 while req1 waits
    req_v_i = 2'b01; req_addr_i[0] = 32'h0000_4000; req_wr_en_i[0] = 1'b0;
    settle();
    chk("t5_yumi", 64'(req_yumi_o), 64'h1);
    tick();
    req_v_i = 2'b00; yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0; v_i = 1'b1; req_ready_and_i = 2'b10; req_v_i = 2'b10;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("t5_ready_%0d", k), 64'(ready_and_o), 64'd0);
      chk($sformatf("t5_busy_%0d", k), 64'(busy_o), 64'd1);
      chk($sformatf("t5_no_yumi_%0d", k), 64'(req_yumi_o), 64'h0);
      chk($sformatf("t5_req_v_o_%0d", k), 64'(req_v_o), 64'h1);
      tick();
    end
    req_ready_and_i = 2'b11;
    settle();
    chk("t5_release_ready", 64'(ready_and_o), 64'd1);
    tick();
    v_i = 1'b0;
    settle();
    chk("t5_next_grant", 64'(req_yumi_o), 64'h2);
    tick();
    req_v_i = 2'b00; yumi_i = 1'b1; v_i = 1'b1;
    settle();
    chk("t5_owner1", 64'(owner_o), 64'd1);
    tick();
    yumi_i = 1'b0; v_i = 1'b0;

    // 6. Reset while req0 owns a transaction in e_resp
    req_v_i = 2'b01; req_addr_i[0] = 32'h0000_5000;
    settle();
    chk("t6_yumi", 64'(req_yumi_o), 64'h1);
    tick();
    req_v_i = 2'b00; yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    settle();
    chk("t6_in_resp", 64'(busy_o), 64'd1);
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    settle();
    chk("t6_busy", 64'(busy_o), 64'd0);
    v_i = 1'b1;
    settle();
    chk("t6_spurious_req_v_o", 64'(req_v_o), 64'h0);
    chk("t6_spurious_ready", 64'(ready_and_o), 64'd0);
    v_i = 1'b0; req_v_i = 2'b11;
    settle();
    chk("t6_req0_first", 64'(req_yumi_o), 64'h1);
    tick();
    req_v_i = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
